chipmunk_bus_target: RTL and testbench

CHIPMUNK_BUS_TARGET -- requirements
Module: chipmunk_bus_target

---
 rtl/chipmunk_bus_target.sv | 174 +++++++++++++++++
 tb/tb_chipmunk_bus_target.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chipmunk_bus_target.sv
// chipmunk_bus_target: byte RAM plus a 16-register I/O window (console TX FIFO,
// status, timer snapshot, console RX holding byte) behind a simple CPU bus.
// Reads are combinational. Writes are qualified by a clk-low transparent latch.
module chipmunk_bus_target #(
    parameter int addrSize = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [addrSize-1:0] addrBus,
    input  logic [7:0]          dataBusWrite,
    input  logic                weMem,
    output logic [7:0]          dataBus,
    output logic [7:0]          txData,
    output logic                txValid,
    input  logic                txReady,
    input  logic [7:0]          rxData,
    input  logic                rxValid,
    output logic                rxReady,
    input  logic                loadEn,
    input  logic [addrSize-1:0] loadAddr,
    input  logic [7:0]          loadData
);

    localparam int DEPTH = 1 << addrSize;

    // I/O register offsets inside the top 16 addresses
    localparam logic [3:0] OFF_CDATA  = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_TLO    = 4'd2;
    localparam logic [3:0] OFF_THI    = 4'd3;
    localparam logic [3:0] OFF_CIN    = 4'd4;

    logic [7:0]  mem_q [DEPTH];

    logic        wr_lat_q;
    logic [7:0]  fifo_q [8];
    logic [7:0]  fifo_d [8];
    logic [2:0]  wptr_q, wptr_d;
    logic [2:0]  rptr_q, rptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        rx_full_q, rx_full_d;
    logic [7:0]  rx_hold_q, rx_hold_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] snap_q, snap_d;

    logic        cur_io, load_io;
    logic [3:0]  off;
    logic        cpu_wr, io_wr;
    logic        tx_push, tx_pop, tx_accept, tx_full, tx_empty;
    logic        rx_accept;
    logic [7:0]  status;

    assign cur_io   = &addrBus[addrSize-1:4];
    assign load_io  = &loadAddr[addrSize-1:4];
    assign off      = addrBus[3:0];

    // A preload in the same cycle suppresses any CPU write
    assign cpu_wr    = wr_lat_q && !loadEn;
    assign io_wr     = cpu_wr && cur_io;

    assign tx_full   = (cnt_q == 4'd8);
    assign tx_empty  = (cnt_q == 4'd0);
    assign tx_pop    = !tx_empty && txReady;
    assign tx_push   = io_wr && (off == OFF_CDATA);
    // When full, a push only fits if the head leaves on the same edge
    assign tx_accept = tx_push && (!tx_full || tx_pop);
    assign rx_accept = rxValid && !rx_full_q;

    assign txValid   = !tx_empty;
    assign txData    = fifo_q[rptr_q];
    assign rxReady   = !rx_full_q;
    assign status    = {ovf_q, rx_full_q, tx_full, tx_empty, cnt_q};

    // Write strobe latch: follows !weMem while clk is low, holds through the high phase
    always_latch begin
        if (!reset)
            wr_lat_q <= 1'b0;
        else if (!clk)
            wr_lat_q <= !weMem;
    end

    // RAM: preload port has priority; I/O addresses never touch the array
    always_ff @(posedge clk) begin
        if (loadEn) begin
            if (!load_io)
                mem_q[loadAddr] <= loadData;
        end else if (wr_lat_q && !cur_io) begin
            mem_q[addrBus] <= dataBusWrite;
        end
    end

    // Combinational read mux, no side effects
    always_comb begin
        dataBus = 8'h00;
        if (cur_io) begin
            case (off)
                OFF_STATUS: dataBus = status;
                OFF_TLO:    dataBus = snap_q[7:0];
                OFF_THI:    dataBus = snap_q[15:8];
                OFF_CIN:    dataBus = rx_hold_q;
                default:    dataBus = 8'h00;
            endcase
        end else begin
            dataBus = mem_q[addrBus];
        end
    end

    // Next-state for FIFO, status flags, RX holding byte and timer
    always_comb begin
        fifo_d    = fifo_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        rx_full_d = rx_full_q;
        rx_hold_d = rx_hold_q;
        timer_d   = timer_q + 16'd1;
        snap_d    = snap_q;

        if (tx_pop)
            rptr_d = rptr_q + 3'd1;
        if (tx_accept) begin
            fifo_d[wptr_q] = dataBusWrite;
            wptr_d         = wptr_q + 3'd1;
        end
        if (tx_accept && !tx_pop)
            cnt_d = cnt_q + 4'd1;
        else if (!tx_accept && tx_pop)
            cnt_d = cnt_q - 4'd1;

        if (tx_push && !tx_accept)
            ovf_d = 1'b1;
        if (io_wr && (off == OFF_STATUS))
            ovf_d = 1'b0;

        if (io_wr && (off == OFF_TLO))
            snap_d = timer_q;

        // Clear first so a same-edge accept (only possible when empty) wins
        if (io_wr && (off == OFF_CIN))
            rx_full_d = 1'b0;
        if (rx_accept) begin
            rx_full_d = 1'b1;
            rx_hold_d = rxData;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) fifo_q[i] <= 8'h00;
            wptr_q    <= 3'd0;
            rptr_q    <= 3'd0;
            cnt_q     <= 4'd0;
            ovf_q     <= 1'b0;
            rx_full_q <= 1'b0;
            rx_hold_q <= 8'h00;
            timer_q   <= 16'h0000;
            snap_q    <= 16'h0000;
        end else begin
            fifo_q    <= fifo_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            rx_full_q <= rx_full_d;
            rx_hold_q <= rx_hold_d;
            timer_q   <= timer_d;
            snap_q    <= snap_d;
        end
    end

endmodule

// File: tb/tb_chipmunk_bus_target.sv
// Directed bench for chipmunk_bus_target: RAM, I/O registers, TX FIFO, RX, timer, reset.
module tb_chipmunk_bus_target;

    localparam logic [11:0] IO_CDATA  = 12'hFF0;
    localparam logic [11:0] IO_STATUS = 12'hFF1;
    localparam logic [11:0] IO_TLO    = 12'hFF2;
    localparam logic [11:0] IO_THI    = 12'hFF3;
    localparam logic [11:0] IO_CIN    = 12'hFF4;
    localparam logic [11:0] IO_OFF5   = 12'hFF5;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] addrBus;
    logic [7:0]  dataBusWrite;
    logic        weMem;
    logic [7:0]  dataBus;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        loadEn;
    logic [11:0] loadAddr;
    logic [7:0]  loadData;

    int checks   = 0;
    int failures = 0;

    chipmunk_bus_target #(.addrSize(12)) dut (
        .clk(clk), .reset(reset), .addrBus(addrBus), .dataBusWrite(dataBusWrite),
        .weMem(weMem), .dataBus(dataBus), .txData(txData), .txValid(txValid),
        .txReady(txReady), .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
        .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData)
    );

    always #5 clk = ~clk;

    // CPU write: weMem low for the clk-low half, commit at the following posedge
    task automatic cpu_wr(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        addrBus = a; dataBusWrite = d; weMem = 1'b0;
        @(posedge clk);
        #1 weMem = 1'b1;
    endtask

    task automatic ld(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        loadEn = 1'b1; loadAddr = a; loadData = d;
        @(posedge clk);
        #1 loadEn = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [7:0] d);
        @(negedge clk);
        addrBus = a;
        #1 d = dataBus;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        if (txValid !== 1'b0) begin $display("FAIL rst_txValid got=%b exp=0", txValid); failures++; end
        checks++;
        if (rxReady !== 1'b1) begin $display("FAIL rst_rxReady got=%b exp=1", rxReady); failures++; end
        checks++;
        rd(IO_STATUS, v);
        if (v !== 8'h10) begin $display("FAIL rst_status got=%h exp=10", v); failures++; end
        checks++;
        rd(IO_TLO, v);
        if (v !== 8'h00) begin $display("FAIL rst_snap_lo got=%h exp=00", v); failures++; end
        checks++;
        rd(IO_CIN, v);
        if (v !== 8'h00) begin $display("FAIL rst_rxhold got=%h exp=00", v); failures++; end
        checks++;
    endtask

    task automatic test_ram;
        logic [7:0] v;
        ld(12'h100, 8'hA9);
        rd(12'h100, v);
        if (v !== 8'hA9) begin $display("FAIL preload got=%h exp=a9", v); failures++; end
        checks++;
        cpu_wr(12'h1FF, 8'h55);
        rd(12'h1FF, v);
        if (v !== 8'h55) begin $display("FAIL cpu_write got=%h exp=55", v); failures++; end
        checks++;
        // Preload and CPU write on the same edge: CPU write is dropped
        ld(12'h201, 8'h00);
        @(negedge clk);
        loadEn = 1'b1; loadAddr = 12'h200; loadData = 8'h11;
        addrBus = 12'h201; dataBusWrite = 8'h22; weMem = 1'b0;
        @(posedge clk);
        #1 loadEn = 1'b0; weMem = 1'b1;
        rd(12'h200, v);
        if (v !== 8'h11) begin $display("FAIL load_prio_load got=%h exp=11", v); failures++; end
        checks++;
        rd(12'h201, v);
        if (v !== 8'h00) begin $display("FAIL load_prio_cpu got=%h exp=00", v); failures++; end
        checks++;
    endtask

    task automatic test_io_misc;
        logic [7:0] v;
        cpu_wr(IO_OFF5, 8'hFF);
        rd(IO_OFF5, v);
        if (v !== 8'h00) begin $display("FAIL off5_read got=%h exp=00", v); failures++; end
        checks++;
        cpu_wr(IO_THI, 8'hEE);
        rd(IO_THI, v);
        if (v !== 8'h00) begin $display("FAIL thi_write_ignored got=%h exp=00", v); failures++; end
        checks++;
        rd(IO_STATUS, v);
        if (v !== 8'h10) begin $display("FAIL io_misc_status got=%h exp=10", v); failures++; end
        checks++;
    endtask

    task automatic test_tx_fill;
        logic [7:0] v;
        txReady = 1'b0;
        for (int i = 0; i < 9; i++) cpu_wr(IO_CDATA, 8'h41 + 8'(i));
        rd(IO_STATUS, v);
        if (v !== 8'hA8) begin $display("FAIL txfill_status got=%h exp=a8", v); failures++; end
        checks++;
        rd(IO_CDATA, v);
        if (v !== 8'h00) begin $display("FAIL cdata_read got=%h exp=00", v); failures++; end
        checks++;
        @(negedge clk);
        txReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (txValid !== 1'b1 || txData !== 8'h41 + 8'(i)) begin
                $display("FAIL txfill_data%0d got=%b/%h exp=1/%h", i, txValid, txData, 8'h41 + 8'(i));
                failures++;
            end
            checks++;
            @(negedge clk);
        end
        #1;
        if (txValid !== 1'b0) begin $display("FAIL txfill_drained got=%b exp=0", txValid); failures++; end
        checks++;
        txReady = 1'b0;
        rd(IO_STATUS, v);
        if (v !== 8'h90) begin $display("FAIL txfill_status_empty got=%h exp=90", v); failures++; end
        checks++;
        cpu_wr(IO_STATUS, 8'h00);
        rd(IO_STATUS, v);
        if (v !== 8'h10) begin $display("FAIL ovf_clear got=%h exp=10", v); failures++; end
        checks++;
    endtask

    task automatic test_full_pop;
        logic [7:0] v;
        txReady = 1'b0;
        for (int i = 0; i < 8; i++) cpu_wr(IO_CDATA, 8'h01 + 8'(i));
        @(negedge clk);
        addrBus = IO_CDATA; dataBusWrite = 8'h5A; weMem = 1'b0; txReady = 1'b1;
        @(posedge clk);
        #1 weMem = 1'b1; txReady = 1'b0;
        rd(IO_STATUS, v);
        if (v !== 8'h28) begin $display("FAIL fullpop_status got=%h exp=28", v); failures++; end
        checks++;
        @(negedge clk);
        txReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            v = (i == 7) ? 8'h5A : 8'h02 + 8'(i);
            if (txValid !== 1'b1 || txData !== v) begin
                $display("FAIL fullpop_data%0d got=%b/%h exp=1/%h", i, txValid, txData, v);
                failures++;
            end
            checks++;
            @(negedge clk);
        end
        txReady = 1'b0;
        rd(IO_STATUS, v);
        if (v !== 8'h10) begin $display("FAIL fullpop_status_end got=%h exp=10", v); failures++; end
        checks++;
    endtask

    task automatic test_rx;
        logic [7:0] v;
        @(negedge clk);
        rxValid = 1'b1; rxData = 8'h7E;
        @(posedge clk);
        #1 rxValid = 1'b0;
        if (rxReady !== 1'b0) begin $display("FAIL rx_ready_low got=%b exp=0", rxReady); failures++; end
        checks++;
        rd(IO_STATUS, v);
        if (v[6] !== 1'b1) begin $display("FAIL rx_status_bit6 got=%b exp=1", v[6]); failures++; end
        checks++;
        // A second byte offered while full must not overwrite the holding byte
        @(negedge clk);
        rxValid = 1'b1; rxData = 8'h99;
        @(posedge clk);
        #1 rxValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd(IO_CIN, v);
            if (v !== 8'h7E) begin $display("FAIL rx_read%0d got=%h exp=7e", i, v); failures++; end
            checks++;
        end
        cpu_wr(IO_CIN, 8'h00);
        if (rxReady !== 1'b1) begin $display("FAIL rx_clear got=%b exp=1", rxReady); failures++; end
        checks++;
        // Clear and accept on the same edge while empty: accept wins
        @(negedge clk);
        addrBus = IO_CIN; weMem = 1'b0; rxValid = 1'b1; rxData = 8'h33;
        @(posedge clk);
        #1 weMem = 1'b1; rxValid = 1'b0;
        if (rxReady !== 1'b0) begin $display("FAIL rx_accept_wins got=%b exp=0", rxReady); failures++; end
        checks++;
        rd(IO_CIN, v);
        if (v !== 8'h33) begin $display("FAIL rx_accept_data got=%h exp=33", v); failures++; end
        checks++;
    endtask

    task automatic test_reset_midstream;
        logic [7:0] v;
        txReady = 1'b0;
        for (int i = 0; i < 3; i++) cpu_wr(IO_CDATA, 8'hC0 + 8'(i));
        rd(IO_STATUS, v);
        if (v !== 8'h43) begin $display("FAIL mid_status_pre got=%h exp=43", v); failures++; end
        checks++;
        #2 reset = 1'b0;
        #1;
        if (txValid !== 1'b0) begin $display("FAIL mid_txValid got=%b exp=0", txValid); failures++; end
        checks++;
        addrBus = IO_STATUS;
        #1;
        if (dataBus !== 8'h10) begin $display("FAIL mid_status got=%h exp=10", dataBus); failures++; end
        checks++;
        addrBus = 12'h100;
        #1;
        if (dataBus !== 8'hA9) begin $display("FAIL mid_ram got=%h exp=a9", dataBus); failures++; end
        checks++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_timer;
        logic [7:0] lo, hi;
        @(negedge clk);
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (70000) @(posedge clk);
        cpu_wr(IO_TLO, 8'h00);
        rd(IO_TLO, lo);
        rd(IO_THI, hi);
        if ({hi, lo} !== 16'h1170) begin $display("FAIL timer_snap got=%h exp=1170", {hi, lo}); failures++; end
        checks++;
        repeat (5) @(posedge clk);
        rd(IO_TLO, lo);
        rd(IO_THI, hi);
        if ({hi, lo} !== 16'h1170) begin $display("FAIL timer_stable got=%h exp=1170", {hi, lo}); failures++; end
        checks++;
    endtask

    initial begin
        reset = 1'b0; addrBus = '0; dataBusWrite = '0; weMem = 1'b1;
        txReady = 1'b0; rxData = '0; rxValid = 1'b0;
        loadEn = 1'b0; loadAddr = '0; loadData = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_ram();
        test_io_misc();
        test_tx_fill();
        test_full_pop();
        test_rx();
        test_reset_midstream();
        test_timer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
